// File: rtl/memory_arbiter_pkg.sv
// Shared types and defaults for the round-robin memory arbiter.
//   state_t         : transaction FSM states (IDLE, ISSUE, CAPTURE)
//   *_DEF           : default parameter values for the arbiter
//   idx_width()     : width of a client index for a given client count
package memory_arbiter_pkg;

    localparam int unsigned NUM_CLIENTS_DEF = 4;
    localparam int unsigned ADDR_W_DEF      = 8;
    localparam int unsigned DATA_W_DEF      = 32;

    // Client index width; never below one bit so a 1-bit index is still legal
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned IDX_W_DEF = idx_width(NUM_CLIENTS_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// Combinational round-robin picker: chooses the first set request scanning
// upward from i_ptr+1 with wrap-around.
//   i_req     : request vector
//   i_ptr     : index of the most recently served client
//   o_pick_c  : one-hot winner (all zero when nothing is requested)
//   o_idx_c   : index of the winner
//   o_valid_c : at least one request is set
module rr_picker
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = NUM_CLIENTS_DEF,
    parameter int unsigned IDX_W       = IDX_W_DEF
) (
    input  logic [NUM_CLIENTS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_ptr,
    output logic [NUM_CLIENTS-1:0] o_pick_c,
    output logic [IDX_W-1:0]       o_idx_c,
    output logic                   o_valid_c
);

    int unsigned w_dist;
    int unsigned w_best;

    // Distance of client j from the scan start is (j - ptr - 1) mod N;
    // the requester with the smallest distance wins.
    always_comb begin
        w_dist    = 0;
        w_best    = NUM_CLIENTS;
        o_idx_c   = '0;
        o_valid_c = |i_req;
        o_pick_c  = '0;
        for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
            w_dist = (j + 2 * NUM_CLIENTS - 1 - 32'(i_ptr)) % NUM_CLIENTS;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_idx_c = IDX_W'(j);
            end
        end
        for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
            o_pick_c[j] = o_valid_c && (o_idx_c == IDX_W'(j));
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter multiplexing NUM_CLIENTS requesters onto one port of a
// 256x32 memory with registered (1-cycle) read data. Each grant performs a
// single 3-cycle transaction: IDLE (select) -> ISSUE (memEnabled high) ->
// CAPTURE (memDataOut valid) -> done pulse in the following IDLE cycle.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req/rw/addr/wdata     : per-client request level, 1=read/0=write, packed address/data
//   lock                  : per-client grant hold, effective only with ARB_LOCK_EN
//   grant/done            : one-hot owner (ISSUE..CAPTURE) and one-cycle completion pulse
//   rdata                 : read data, valid in the done cycle of a read, held afterwards
//   mem*                  : memory port (memDataOut is the memory's registered output)
// Build option: define ARB_LOCK_EN to let a locked previous owner be reselected.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = NUM_CLIENTS_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLIENTS-1:0]        req,
    input  logic [NUM_CLIENTS-1:0]        rw,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
    input  logic [NUM_CLIENTS-1:0]        lock,
    output logic [NUM_CLIENTS-1:0]        grant,
    output logic [NUM_CLIENTS-1:0]        done,
    output logic [DATA_W-1:0]             rdata,
    output logic [ADDR_W-1:0]             memAddress,
    output logic                          memReadWrite,
    output logic [DATA_W-1:0]             memDataIn,
    output logic                          memEnabled,
    input  logic [DATA_W-1:0]             memDataOut
);

    localparam int unsigned IDX_W = idx_width(NUM_CLIENTS);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       r_idx,      w_idx_nxt;
    logic [IDX_W-1:0]       r_ptr,      w_ptr_nxt;
    logic [NUM_CLIENTS-1:0] r_grant,    w_grant_nxt;
    logic [NUM_CLIENTS-1:0] r_done,     w_done_nxt;
    logic [DATA_W-1:0]      r_rdata,    w_rdata_nxt;
    logic                   r_mem_en,   w_mem_en_nxt;
    logic [ADDR_W-1:0]      r_mem_addr, w_mem_addr_nxt;
    logic                   r_mem_rw,   w_mem_rw_nxt;
    logic [DATA_W-1:0]      r_mem_din,  w_mem_din_nxt;

    logic [NUM_CLIENTS-1:0] w_rr_pick;
    logic [IDX_W-1:0]       w_rr_idx;
    logic                   w_rr_valid;

    logic [NUM_CLIENTS-1:0] w_sel_pick;
    logic [IDX_W-1:0]       w_sel_idx;
    logic                   w_sel_valid;
    logic                   w_sel_rw;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_wdata;

    rr_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_rr_picker (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_pick_c  (w_rr_pick),
        .o_idx_c   (w_rr_idx),
        .o_valid_c (w_rr_valid)
    );

`ifdef ARB_LOCK_EN
    // r_ptr equals the previous owner once a transaction has completed its
    // ISSUE cycle; r_owner_vld guards the reset value of r_ptr.
    logic                   r_owner_vld, w_owner_vld_nxt;
    logic                   w_lock_hold;
    logic [NUM_CLIENTS-1:0] w_lock_pick;

    always_comb begin
        w_lock_hold = r_owner_vld && lock[r_ptr] && req[r_ptr];
        w_lock_pick = '0;
        for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
            w_lock_pick[j] = (r_ptr == IDX_W'(j));
        end
        if (w_lock_hold) begin
            w_sel_pick  = w_lock_pick;
            w_sel_idx   = r_ptr;
            w_sel_valid = 1'b1;
        end else begin
            w_sel_pick  = w_rr_pick;
            w_sel_idx   = w_rr_idx;
            w_sel_valid = w_rr_valid;
        end
    end
`else
    // Lock is accepted on the port but has no effect in this build
    logic w_unused_lock;
    assign w_unused_lock = ^lock;

    always_comb begin
        w_sel_pick  = w_rr_pick;
        w_sel_idx   = w_rr_idx;
        w_sel_valid = w_rr_valid;
    end
`endif

    // Input mux: route the selected client's command fields
    always_comb begin
        w_sel_rw    = 1'b1;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
            if (w_sel_idx == IDX_W'(j)) begin
                w_sel_rw    = rw[j];
                w_sel_addr  = addr[j*ADDR_W +: ADDR_W];
                w_sel_wdata = wdata[j*DATA_W +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_ptr_nxt      = r_ptr;
        w_grant_nxt    = r_grant;
        w_done_nxt     = '0;
        w_rdata_nxt    = r_rdata;
        w_mem_en_nxt   = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_rw_nxt   = r_mem_rw;
        w_mem_din_nxt  = r_mem_din;
`ifdef ARB_LOCK_EN
        w_owner_vld_nxt = r_owner_vld;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_sel_valid) begin
                    w_state_nxt    = ISSUE;
                    w_idx_nxt      = w_sel_idx;
                    w_grant_nxt    = w_sel_pick;
                    w_mem_en_nxt   = 1'b1;
                    w_mem_addr_nxt = w_sel_addr;
                    w_mem_rw_nxt   = w_sel_rw;
                    w_mem_din_nxt  = w_sel_wdata;
                end
            end
            ISSUE: begin
                // Memory samples the command at the edge closing this cycle
                w_state_nxt = CAPTURE;
                w_ptr_nxt   = r_idx;
`ifdef ARB_LOCK_EN
                w_owner_vld_nxt = 1'b1;
`endif
            end
            CAPTURE: begin
                if (r_mem_rw) begin
                    w_rdata_nxt = memDataOut;
                end
                w_done_nxt  = r_grant;
                w_grant_nxt = '0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_ptr      <= IDX_W'(NUM_CLIENTS - 1);
            r_grant    <= '0;
            r_done     <= '0;
            r_rdata    <= '0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_rw   <= 1'b1;
            r_mem_din  <= '0;
`ifdef ARB_LOCK_EN
            r_owner_vld <= 1'b0;
`endif
        end else begin
            r_idx      <= w_idx_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_done     <= w_done_nxt;
            r_rdata    <= w_rdata_nxt;
            r_mem_en   <= w_mem_en_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_rw   <= w_mem_rw_nxt;
            r_mem_din  <= w_mem_din_nxt;
`ifdef ARB_LOCK_EN
            r_owner_vld <= w_owner_vld_nxt;
`endif
        end
    end

    assign grant        = r_grant;
    assign done         = r_done;
    assign rdata        = r_rdata;
    assign memEnabled   = r_mem_en;
    assign memAddress   = r_mem_addr;
    assign memReadWrite = r_mem_rw;
    assign memDataIn    = r_mem_din;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a 256x32 registered-output memory
// model as the slave. Memory location i initially holds 0xA5000000 | i.
module tb_memory_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [3:0]   rw;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [3:0]   lock;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic [31:0]  rdata;
    logic [7:0]   memAddress;
    logic         memReadWrite;
    logic [31:0]  memDataIn;
    logic         memEnabled;
    logic [31:0]  memDataOut;

    logic [31:0]  mem [256];

    int n_pass;
    int n_total;

    memory_arbiter #(
        .NUM_CLIENTS (4),
        .ADDR_W      (8),
        .DATA_W      (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .rw           (rw),
        .addr         (addr),
        .wdata        (wdata),
        .lock         (lock),
        .grant        (grant),
        .done         (done),
        .rdata        (rdata),
        .memAddress   (memAddress),
        .memReadWrite (memReadWrite),
        .memDataIn    (memDataIn),
        .memEnabled   (memEnabled),
        .memDataOut   (memDataOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared memory: read data registered, writes on enabled edge
    initial begin
        memDataOut <= '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
        forever begin
            @(posedge clk);
            if (memEnabled === 1'b1) begin
                if (memReadWrite) memDataOut <= mem[memAddress];
                else              mem[memAddress] = memDataIn;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Waits (bounded) for the next done pulse; checks owner and latency in cycles
    task automatic wait_done(input int c, input int exp_cyc, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((done == 4'h0) && (n < 20));
        check({tag, " done"}, 32'(done), 32'(1) << c);
        check({tag, " latency"}, 32'(n), 32'(exp_cyc));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        req     = '0;
        rw      = '1;
        lock    = '0;
        addr    = {8'h23, 8'h22, 8'h21, 8'h20};
        wdata   = '0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst grant",  32'(grant), 32'h0);
        check("rst done",   32'(done), 32'h0);
        check("rst rdata",  rdata, 32'h0);
        check("rst memEn",  32'(memEnabled), 32'h0);
        check("rst memAdr", 32'(memAddress), 32'h0);
        check("rst memRW",  32'(memReadWrite), 32'h1);
        check("rst memDin", memDataIn, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Client 0 write then read of 0x10
        rw[0]         = 1'b0;
        addr[7:0]     = 8'h10;
        wdata[31:0]   = 32'hDEAD_BEEF;
        req[0]        = 1'b1;
        @(negedge clk);
        check("t1 grant", 32'(grant), 32'h1);
        check("t1 memEn", 32'(memEnabled), 32'h1);
        check("t1 memAdr", 32'(memAddress), 32'h10);
        check("t1 memRW", 32'(memReadWrite), 32'h0);
        check("t1 memDin", memDataIn, 32'hDEAD_BEEF);
        wait_done(0, 2, "t1 wr");
        check("t1 mem[10]", mem[8'h10], 32'hDEAD_BEEF);
        rw[0] = 1'b1;
        wait_done(0, 3, "t1 rd");
        check("t1 rdata", rdata, 32'hDEAD_BEEF);
        req[0]    = 1'b0;
        addr[7:0] = 8'h20;
        @(negedge clk);
        check("t1 single pulse", 32'(done), 32'h0);

        // All four clients from reset: order 0,1,2,3
        do_reset();
        req = 4'hF;
        for (int c = 0; c < 4; c++) begin
            wait_done(c, 3, "t2");
            check("t2 rdata", rdata, 32'hA500_0020 + 32'(c));
            req[c] = 1'b0;
        end
        @(negedge clk);

        // Client 2 holds, client 1 requests once: order 2,1,2,2
        req[2] = 1'b1;
        @(negedge clk);
        check("t3 grant", 32'(grant), 32'h4);
        req[1] = 1'b1;
        wait_done(2, 2, "t3 a");
        wait_done(1, 3, "t3 b");
        check("t3 rdata1", rdata, 32'hA500_0021);
        req[1] = 1'b0;
        wait_done(2, 3, "t3 c");
        check("t3 rdata2", rdata, 32'hA500_0022);
        wait_done(2, 3, "t3 d");
        req[2] = 1'b0;
        @(negedge clk);

        // Client 3 writes 0xFF and drops req during CAPTURE
        rw[3]          = 1'b0;
        addr[31:24]    = 8'hFF;
        wdata[127:96]  = 32'h1234_5678;
        req[3]         = 1'b1;
        @(negedge clk);
        check("t4 grant", 32'(grant), 32'h8);
        @(negedge clk);
        check("t4 capture memEn", 32'(memEnabled), 32'h0);
        req[3] = 1'b0;
        wait_done(3, 1, "t4");
        check("t4 rdata held", rdata, 32'hA500_0022);
        check("t4 mem[FF]", mem[8'hFF], 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4 no regrant", 32'(grant), 32'h0);
            check("t4 no done", 32'(done), 32'h0);
        end

        // Reset during ISSUE aborts a write to address 0
        rw[0]       = 1'b0;
        addr[7:0]   = 8'h00;
        wdata[31:0] = 32'hCAFE_F00D;
        req[0]      = 1'b1;
        @(negedge clk);
        check("t5 issue memEn", 32'(memEnabled), 32'h1);
        check("t5 issue grant", 32'(grant), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5 rst memEn", 32'(memEnabled), 32'h0);
        check("t5 rst grant", 32'(grant), 32'h0);
        req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5 mem[0]", mem[8'h00], 32'hA500_0000);
        check("t5 done", 32'(done), 32'h0);
        check("t5 rdata", rdata, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5 idle done", 32'(done), 32'h0);
        end

        // Lock: client 1 holds lock and req while client 0 also requests
        rw         = '1;
        addr[7:0]  = 8'h31;
        addr[15:8] = 8'h30;
        req[1]     = 1'b1;
        lock[1]    = 1'b1;
        wait_done(1, 3, "t6 a");
        check("t6 rdata a", rdata, 32'hA500_0030);
        req[0] = 1'b1;
`ifdef ARB_LOCK_EN
        wait_done(1, 3, "t6 b");
        wait_done(1, 3, "t6 c");
        lock[1] = 1'b0;
        req[1]  = 1'b0;
        wait_done(0, 3, "t6 d");
        check("t6 rdata d", rdata, 32'hA500_0031);
        req[0] = 1'b0;
`else
        wait_done(0, 3, "t6 b");
        check("t6 rdata b", rdata, 32'hA500_0031);
        req[0] = 1'b0;
        wait_done(1, 3, "t6 c");
        req[1]  = 1'b0;
        lock[1] = 1'b0;
`endif
        @(negedge clk);
        check("t6 end grant", 32'(grant), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
